// File: rtl/wave_gen_top.sv
// Burst waveform generator: programmable high/low phase lengths, burst or continuous
// period count, graceful stop at period boundary, one-clock done pulse.
module wave_gen_top #(
    parameter logic [31:0] DEF_HIGH = 32'd6250,
    parameter logic [31:0] DEF_LOW  = 32'd6250
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic        start,
    input  logic        stop,
    input  logic [31:0] cfg_high,
    input  logic [31:0] cfg_low,
    input  logic [15:0] cfg_num,
    output logic        signal_out,
    output logic        busy,
    output logic        done,
    output logic [15:0] period_cnt
);

    localparam int unsigned LEN_W = 32;
    localparam int unsigned CNT_W = 16;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] HIGH = 2'd1;
    localparam logic [1:0] LOW  = 2'd2;

    typedef struct packed {
        logic [LEN_W-1:0] hi_len;
        logic [LEN_W-1:0] lo_len;
        logic [CNT_W-1:0] num;
    } burst_cfg_t;

    logic [1:0]       state_q, state_d;
    logic [LEN_W-1:0] phase_q, phase_d;
    logic [CNT_W-1:0] period_d;
    burst_cfg_t       cfg_q, cfg_d;
    logic             stop_req_q, stop_req_d;
    logic             signal_d, busy_d, done_d;

    logic             hi_last_c, lo_last_c, burst_end_c;
    logic [CNT_W-1:0] period_inc_c;

    // Phase end detection and end-of-burst decision at the final LOW clock
    always_comb begin
        hi_last_c    = (phase_q == cfg_q.hi_len - LEN_W'(1));
        lo_last_c    = (phase_q == cfg_q.lo_len - LEN_W'(1));
        period_inc_c = period_cnt + CNT_W'(1);
        burst_end_c  = ((cfg_q.num != '0) && (period_inc_c == cfg_q.num))
                       || stop_req_q || stop;
    end

    // Next-state and next-output logic
    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        period_d   = period_cnt;
        cfg_d      = cfg_q;
        stop_req_d = stop_req_q;
        signal_d   = signal_out;
        busy_d     = busy;
        done_d     = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    cfg_d.hi_len = (cfg_high == '0) ? DEF_HIGH : cfg_high;
                    cfg_d.lo_len = (cfg_low == '0) ? DEF_LOW : cfg_low;
                    cfg_d.num    = cfg_num;
                    period_d     = '0;
                    phase_d      = '0;
                    stop_req_d   = 1'b0;
                    state_d      = HIGH;
                    signal_d     = 1'b1;
                    busy_d       = 1'b1;
                end
            end

            HIGH: begin
                if (stop) begin
                    stop_req_d = 1'b1;
                end
                if (hi_last_c) begin
                    phase_d  = '0;
                    state_d  = LOW;
                    signal_d = 1'b0;
                end else begin
                    phase_d = phase_q + LEN_W'(1);
                end
            end

            LOW: begin
                if (stop) begin
                    stop_req_d = 1'b1;
                end
                if (lo_last_c) begin
                    period_d = period_inc_c;
                    phase_d  = '0;
                    if (burst_end_c) begin
                        state_d = IDLE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        state_d  = HIGH;
                        signal_d = 1'b1;
                    end
                end else begin
                    phase_d = phase_q + LEN_W'(1);
                end
            end

            default: begin
                state_d  = IDLE;
                signal_d = 1'b0;
                busy_d   = 1'b0;
            end
        endcase
    end

    // State, counters, latched config and registered outputs
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q    <= IDLE;
            phase_q    <= '0;
            period_cnt <= '0;
            cfg_q      <= '0;
            stop_req_q <= 1'b0;
            signal_out <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            period_cnt <= period_d;
            cfg_q      <= cfg_d;
            stop_req_q <= stop_req_d;
            signal_out <= signal_d;
            busy       <= busy_d;
            done       <= done_d;
        end
    end

endmodule

// File: tb/tb_wave_gen_top.sv
// Self-checking bench for wave_gen_top: bursts compared cycle by cycle against an
// arithmetic model of the waveform (phase position = cycles since start mod period).
module tb_wave_gen_top;

    logic        sys_clk = 1'b0;
    logic        sys_rst;
    logic        start;
    logic        stop;
    logic [31:0] cfg_high;
    logic [31:0] cfg_low;
    logic [15:0] cfg_num;
    logic        signal_out;
    logic        busy;
    logic        done;
    logic [15:0] period_cnt;

    int checks = 0;
    int errors = 0;

    always #5 sys_clk = ~sys_clk;

    wave_gen_top dut (
        .sys_clk    (sys_clk),
        .sys_rst    (sys_rst),
        .start      (start),
        .stop       (stop),
        .cfg_high   (cfg_high),
        .cfg_low    (cfg_low),
        .cfg_num    (cfg_num),
        .signal_out (signal_out),
        .busy       (busy),
        .done       (done),
        .period_cnt (period_cnt)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic check_outputs(input string tag, input bit sig_e, input bit busy_e,
                                 input bit done_e, input logic [15:0] pc_e);
        check({tag, " signal_out"}, 32'(signal_out), 32'(sig_e));
        check({tag, " busy"},       32'(busy),       32'(busy_e));
        check({tag, " done"},       32'(done),       32'(done_e));
        check({tag, " period_cnt"}, 32'(period_cnt), 32'(pc_e));
    endtask

    // Launches a burst and checks every cycle from the accepting edge (k = 0) onward.
    // stop_k: relative edge at which stop is sampled (0 = never); max_k bounds
    // continuous runs that are never stopped. hold keeps start high for a
    // back-to-back burst; noise scrambles start/cfg while busy.
    task automatic run_burst(input int ch, input int cl, input int cn, input int stop_k,
                             input int max_k, input bit hold, input bit noise,
                             input string name);
        int hi, lo, p, n, m, total, last_k;
        bit busy_e, sig_e;
        hi = (ch == 0) ? 6250 : ch;
        lo = (cl == 0) ? 6250 : cl;
        p  = hi + lo;
        n  = cn;
        if (stop_k > 0) begin
            m = (stop_k + p - 1) / p;
            if (n == 0 || m < n) n = m;
        end
        total  = (n == 0) ? -1 : n * p;
        last_k = (total < 0) ? max_k : total;

        cfg_high = 32'(ch);
        cfg_low  = 32'(cl);
        cfg_num  = 16'(cn);
        start    = 1'b1;
        stop     = 1'($urandom_range(0, 1));
        @(posedge sys_clk);
        #1;
        for (int k = 0; k <= last_k; k++) begin
            busy_e = (total < 0) || (k < total);
            sig_e  = busy_e && ((k % p) < hi);
            check_outputs($sformatf("%s k=%0d", name, k), sig_e, busy_e,
                          (total >= 0) && (k == total), 16'(k / p));
            if (k == last_k) begin
                start    = hold;
                stop     = 1'b0;
                cfg_high = 32'(ch);
                cfg_low  = 32'(cl);
                cfg_num  = 16'(cn);
            end else begin
                start = hold ? 1'b1 : (noise ? 1'($urandom_range(0, 1)) : 1'b0);
                stop  = (k + 1 == stop_k);
                if (noise) begin
                    cfg_high = $urandom;
                    cfg_low  = $urandom;
                    cfg_num  = 16'($urandom);
                end
                @(posedge sys_clk);
                #1;
            end
        end
        if (!hold && total >= 0) begin
            @(posedge sys_clk);
            #1;
            check_outputs({name, " idle_after"}, 1'b0, 1'b0, 1'b0, 16'(n));
        end
    endtask

    initial begin
        int hi_r, lo_r, num_r, stop_r, p_r;
        sys_rst  = 1'b1;
        start    = 1'b0;
        stop     = 1'b0;
        cfg_high = '0;
        cfg_low  = '0;
        cfg_num  = '0;

        repeat (3) @(posedge sys_clk);
        #1;
        check_outputs("reset", 1'b0, 1'b0, 1'b0, 16'd0);
        sys_rst = 1'b0;

        // stop alone in IDLE must not start anything
        for (int i = 0; i < 6; i++) begin
            stop = 1'($urandom_range(0, 1));
            @(posedge sys_clk);
            #1;
            check_outputs($sformatf("idle_stop i=%0d", i), 1'b0, 1'b0, 1'b0, 16'd0);
        end
        stop = 1'b0;

        run_burst(1, 1, 4, 0, 0, 1'b0, 1'b0, "one_one");
        run_burst(3, 2, 2, 0, 0, 1'b1, 1'b0, "hold_a");
        run_burst(3, 2, 2, 0, 0, 1'b0, 1'b0, "hold_b");
        run_burst(7, 5, 3, 0, 0, 1'b0, 1'b1, "cfg_noise");

        for (int r = 0; r < 8; r++) begin
            hi_r  = int'($urandom_range(1, 12));
            lo_r  = int'($urandom_range(1, 12));
            num_r = int'($urandom_range(0, 5));
            p_r   = hi_r + lo_r;
            if (num_r == 0)
                stop_r = int'($urandom_range(1, 3 * p_r));
            else
                stop_r = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, num_r * p_r)) : 0;
            run_burst(hi_r, lo_r, num_r, stop_r, 0, 1'b0, 1'($urandom_range(0, 1)),
                      $sformatf("rand%0d", r));
        end

        run_burst(4000, 1000, 0, 12000, 0, 1'b0, 1'b0, "stop80");

        // Reset mid-HIGH of the third period: outputs clear without a clock edge
        run_burst(20, 10, 0, 0, 70, 1'b0, 1'b1, "pre_rst");
        #3;
        sys_rst = 1'b1;
        #1;
        check_outputs("async_rst", 1'b0, 1'b0, 1'b0, 16'd0);
        @(posedge sys_clk);
        #1;
        sys_rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge sys_clk);
            #1;
            check_outputs($sformatf("post_rst i=%0d", i), 1'b0, 1'b0, 1'b0, 16'd0);
        end
        run_burst(2, 3, 2, 0, 0, 1'b0, 1'b0, "after_rst");

        run_burst(0, 0, 3, 0, 0, 1'b0, 1'b1, "defaults");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/wave_gen_top.md
WAVE_GEN_TOP -- requirements
Module: wave_gen_top

Interface
REQ-001 The block SHALL have parameter DEF_HIGH, default 32'd6250, giving the high-phase length in clocks used when cfg_high is 0 (62.5 us at 100 MHz).
REQ-002 The block SHALL have parameter DEF_LOW, default 32'd6250, giving the low-phase length in clocks used when cfg_low is 0 (DEF_HIGH + DEF_LOW = 8 kHz, 50 % duty).
REQ-003 The block SHALL have port sys_clk, input, 1 bit: the single clock, rising edge, 100 MHz.
REQ-004 The block SHALL have port sys_rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port start, input, 1 bit: request to begin a burst, sampled only in IDLE.
REQ-006 The block SHALL have port stop, input, 1 bit: graceful stop request, sampled only while busy.
REQ-007 The block SHALL have port cfg_high, input, 32 bits: high-phase length in clocks, where 0 selects DEF_HIGH.
REQ-008 The block SHALL have port cfg_low, input, 32 bits: low-phase length in clocks, where 0 selects DEF_LOW.
REQ-009 The block SHALL have port cfg_num, input, 16 bits: number of periods in the burst, where 0 means continuous.
REQ-010 The block SHALL have port signal_out, output, 1 bit: the generated waveform, registered.
REQ-011 The block SHALL have port busy, output, 1 bit: high while in HIGH or LOW state.
REQ-012 The block SHALL have port done, output, 1 bit: one-clock pulse when a burst or stop completes.
REQ-013 The block SHALL have port period_cnt, output, 16 bits: count of completed periods since the last accepted start.

Function
REQ-014 The block SHALL implement a state machine with states IDLE, HIGH and LOW, and SHALL drive signal_out = 1 only in HIGH and busy = 1 in HIGH or LOW.
REQ-015 In IDLE with start = 1 at edge N, the block SHALL latch hi_len, lo_len and num from cfg_high, cfg_low and cfg_num (zero lengths replaced by their defaults), clear period_cnt and the phase counter, clear stop_req, and enter HIGH, so that signal_out and busy are 1 after edge N.
REQ-016 HIGH SHALL last exactly hi_len clocks, after which the block SHALL enter LOW with the phase counter cleared, so that signal_out falls after edge N + hi_len.
REQ-017 LOW SHALL last exactly lo_len clocks, and at its final clock period_cnt SHALL increment by 1, wrapping from 16'hFFFF to 0.
REQ-018 At the end of LOW, if num != 0 and the incremented period_cnt equals num, or if stop_req = 1, the block SHALL enter IDLE and pulse done = 1 for one clock; otherwise it SHALL re-enter HIGH.
REQ-019 The period SHALL be exactly hi_len + lo_len clocks, with no gap clock between periods.
REQ-020 stop = 1 while busy SHALL set stop_req, the current period SHALL complete in full, and the burst SHALL end at that period's end without truncated pulses.
REQ-021 stop in IDLE SHALL be ignored.
REQ-022 start = 1 and stop = 1 in the same IDLE cycle SHALL accept start and ignore stop.
REQ-023 start while busy SHALL be ignored, and no restart SHALL occur.
REQ-024 cfg_high, cfg_low and cfg_num changes while busy SHALL have no effect until the next accepted start.
REQ-025 start held high through the IDLE return SHALL be accepted on the cycle after done, giving back-to-back bursts separated by exactly one low IDLE clock.
REQ-026 period_cnt SHALL hold its value in IDLE after completion.
REQ-027 The phase counter SHALL be 32 bits wide with an equality compare against length - 1, and hi_len = 1 or lo_len = 1 SHALL produce 1-clock phases.

Reset
REQ-028 sys_rst = 1 SHALL immediately force state IDLE, signal_out = 0, busy = 0, done = 0, period_cnt = 0, the phase counter = 0, stop_req = 0 and the latched config = 0, regardless of clock.
REQ-029 Reset asserted mid-burst SHALL abort the burst without a done pulse, and after release the block SHALL stay IDLE until the next start.

Verification
REQ-030 Scenario: cfg_high = 0, cfg_low = 0, cfg_num = 3, start pulse -> three periods of 6250 high and 6250 low, busy for 37500 clocks, one done pulse, period_cnt = 3.
REQ-031 Scenario: cfg_high = 4000, cfg_low = 1000, cfg_num = 0, stop pulse at clock 12000 -> 80 % duty continuous, ending after the third period (clock 15000), then done and period_cnt = 3.
REQ-032 Scenario: cfg_high = 1, cfg_low = 1, cfg_num = 4 -> signal_out toggles every clock, 1010 1010, then done at clock 8.
REQ-033 Scenario: a start pulse mid-burst with changed cfg_high -> the burst is unaffected and period lengths are unchanged.
REQ-034 Scenario: sys_rst asserted during HIGH -> all outputs are 0 asynchronously with no done pulse, and a start after release runs normally.
REQ-035 Scenario: start held high with cfg_num = 2 -> bursts repeat with exactly one IDLE clock between done and the next rising signal_out.
